// File: rtl/ddr3_tg_pkg.sv
// Shared constants for the DDR3 UI traffic generator: UI command codes, FSM encoding,
// LFSR polynomial/seed and the write/read-back data pattern (DDR3_TG_PRBS_EN selects PRBS data).
package ddr3_tg_pkg;

   localparam logic [2:0] CMD_WRITE = 3'b000;
   localparam logic [2:0] CMD_READ  = 3'b001;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_WRITE   = 3'd1;
   localparam logic [2:0] ST_READ    = 3'd2;
   localparam logic [2:0] ST_WAIT_RD = 3'd3;
   localparam logic [2:0] ST_DONE    = 3'd4;

   // Right-shifting Galois form of x^32 + x^22 + x^2 + x + 1
   localparam logic [31:0] LFSR_POLY    = 32'h8020_0003;
   localparam logic [15:0] LFSR_SEED_LO = 16'hACE1;

   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      return {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0);
   endfunction

   function automatic logic [31:0] lfsr_seed(input logic [15:0] pass);
      return {pass, LFSR_SEED_LO};
   endfunction

   function automatic logic [31:0] pattern(input logic [27:0] addr, input logic [15:0] pass,
                                           input logic [31:0] lfsr);
      logic unused_bits;
`ifdef DDR3_TG_PRBS_EN
      unused_bits = ^{addr, pass};
      return lfsr;
`else
      unused_bits = ^{pass[15:4], lfsr};
      return {pass[3:0], addr};
`endif
   endfunction

endpackage

// File: rtl/ddr3_tg_checker.sv
// Read-back checker: tracks the expected address/pattern for each returned beat, counts beats
// and holds the sticky compare error plus the address of the first mismatch (DDR3_TG_PRBS_EN aware).
module ddr3_tg_checker
   import ddr3_tg_pkg::*;
#(
   parameter int                    ADDR_WIDTH     = 28,
   parameter int                    APP_DATA_WIDTH = 64,
   parameter logic [ADDR_WIDTH-1:0] START_ADDR     = '0,
   parameter int                    NUM_BURSTS     = 256,
   parameter int                    ADDR_STEP      = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic                      active,
   input  logic [15:0]               pass,
   input  logic                      rd_valid,
   input  logic [APP_DATA_WIDTH-1:0] rd_data,
   output logic                      rd_last,
   output logic                      rd_mismatch,
   output logic                      cmp_err,
   output logic [ADDR_WIDTH-1:0]     err_addr
);

   localparam int                    REP      = APP_DATA_WIDTH / 32;
   localparam logic [15:0]           LAST_CNT = 16'(NUM_BURSTS - 1);
   localparam logic [ADDR_WIDTH-1:0] STEP     = ADDR_WIDTH'(ADDR_STEP);

   logic [ADDR_WIDTH-1:0]     exp_addr_q, exp_addr_d;
   logic [15:0]               rd_cnt_q, rd_cnt_d;
   logic                      err_q, err_d;
   logic [ADDR_WIDTH-1:0]     err_addr_q, err_addr_d;
   logic [31:0]               chk_lfsr;
   logic                      beat;
   logic [APP_DATA_WIDTH-1:0] exp_data;

`ifdef DDR3_TG_PRBS_EN
   logic [31:0] lfsr_q, lfsr_d;
   assign chk_lfsr = lfsr_q;
`else
   assign chk_lfsr = 32'h0;
`endif

   // Beats outside READ/WAIT_RD belong to an abandoned pass and are dropped
   assign beat        = active && rd_valid;
   assign exp_data    = {REP{pattern(exp_addr_q[27:0], pass, chk_lfsr)}};
   assign rd_mismatch = beat && (rd_data != exp_data);
   assign rd_last     = beat && (rd_cnt_q == LAST_CNT);
   assign cmp_err     = err_q;
   assign err_addr    = err_addr_q;

   always_comb begin
      exp_addr_d = exp_addr_q;
      rd_cnt_d   = rd_cnt_q;
      err_d      = err_q;
      err_addr_d = err_addr_q;
`ifdef DDR3_TG_PRBS_EN
      lfsr_d     = lfsr_q;
`endif
      if (start) begin
         exp_addr_d = START_ADDR;
         rd_cnt_d   = 16'd0;
`ifdef DDR3_TG_PRBS_EN
         lfsr_d     = lfsr_seed(pass);
`endif
      end else if (beat) begin
         exp_addr_d = exp_addr_q + STEP;
         rd_cnt_d   = rd_cnt_q + 16'd1;
`ifdef DDR3_TG_PRBS_EN
         lfsr_d     = lfsr_step(lfsr_q);
`endif
      end
      if (rd_mismatch) begin
         err_d = 1'b1;
         if (!err_q) err_addr_d = exp_addr_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         exp_addr_q <= '0;
         rd_cnt_q   <= 16'd0;
         err_q      <= 1'b0;
         err_addr_q <= '0;
`ifdef DDR3_TG_PRBS_EN
         lfsr_q     <= 32'h0;
`endif
      end else begin
         exp_addr_q <= exp_addr_d;
         rd_cnt_q   <= rd_cnt_d;
         err_q      <= err_d;
         err_addr_q <= err_addr_d;
`ifdef DDR3_TG_PRBS_EN
         lfsr_q     <= lfsr_d;
`endif
      end
   end

endmodule

// File: rtl/ddr3_traffic_gen.sv
// DDR3 MIG UI traffic generator: writes a pattern over an address window, reads it back and
// checks it in numbered passes. DDR3_TG_PRBS_EN switches the address pattern to LFSR data.
module ddr3_traffic_gen
   import ddr3_tg_pkg::*;
#(
   parameter int                    ADDR_WIDTH     = 28,
   parameter int                    APP_DATA_WIDTH = 64,
   parameter int                    APP_MASK_WIDTH = 8,
   parameter logic [ADDR_WIDTH-1:0] START_ADDR     = '0,
   parameter int                    NUM_BURSTS     = 256,
   parameter int                    ADDR_STEP      = 8,
   parameter int                    STOP_ON_ERR    = 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      init_calib_complete,
   input  logic                      app_rdy,
   input  logic                      app_wdf_rdy,
   input  logic [APP_DATA_WIDTH-1:0] app_rd_data,
   input  logic                      app_rd_data_valid,
   input  logic                      app_rd_data_end,
   output logic [ADDR_WIDTH-1:0]     app_addr,
   output logic [2:0]                app_cmd,
   output logic                      app_en,
   output logic [APP_DATA_WIDTH-1:0] app_wdf_data,
   output logic                      app_wdf_end,
   output logic [APP_MASK_WIDTH-1:0] app_wdf_mask,
   output logic                      app_wdf_wren,
   output logic                      tg_compare_error,
   output logic [15:0]               pass_cnt,
   output logic [ADDR_WIDTH-1:0]     err_addr
);

   localparam int                    REP      = APP_DATA_WIDTH / 32;
   localparam logic [15:0]           LAST_CNT = 16'(NUM_BURSTS - 1);
   localparam logic [ADDR_WIDTH-1:0] STEP     = ADDR_WIDTH'(ADDR_STEP);

   logic [2:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
   logic [15:0]           cmd_cnt_q, cmd_cnt_d;
   logic [15:0]           pass_cnt_q, pass_cnt_d;
   logic [31:0]           gen_lfsr;
   logic                  wr_xfer, rd_xfer, last_cmd;
   logic                  chk_start, chk_active, rd_last, rd_mismatch, err_flag;
   logic                  unused_rd_end;

   assign unused_rd_end = app_rd_data_end;

`ifdef DDR3_TG_PRBS_EN
   logic [31:0] gen_lfsr_q, gen_lfsr_d;
   assign gen_lfsr = gen_lfsr_q;
`else
   assign gen_lfsr = 32'h0;
`endif

   // Handshake: app_en (with app_wdf_wren in WRITE) is held with stable address/data until the
   // cycle the controller's ready(s) are high; that cycle is the transfer, then the next beat shows.
   assign wr_xfer  = (state_q == ST_WRITE) && app_rdy && app_wdf_rdy;
   assign rd_xfer  = (state_q == ST_READ) && app_rdy;
   assign last_cmd = (cmd_cnt_q == LAST_CNT);

   always_comb begin
      state_d    = state_q;
      cmd_addr_d = cmd_addr_q;
      cmd_cnt_d  = cmd_cnt_q;
      pass_cnt_d = pass_cnt_q;
      chk_start  = 1'b0;
`ifdef DDR3_TG_PRBS_EN
      gen_lfsr_d = gen_lfsr_q;
      if (wr_xfer) gen_lfsr_d = lfsr_step(gen_lfsr_q);
`endif
      if (wr_xfer || rd_xfer) begin
         if (last_cmd) begin
            cmd_addr_d = START_ADDR;
            cmd_cnt_d  = 16'd0;
         end else begin
            cmd_addr_d = cmd_addr_q + STEP;
            cmd_cnt_d  = cmd_cnt_q + 16'd1;
         end
      end
      case (state_q)
         ST_IDLE: begin
            if (init_calib_complete) begin
               state_d    = ST_WRITE;
               cmd_addr_d = START_ADDR;
               cmd_cnt_d  = 16'd0;
`ifdef DDR3_TG_PRBS_EN
               gen_lfsr_d = lfsr_seed(pass_cnt_q);
`endif
            end
         end
         ST_WRITE: begin
            if (wr_xfer && last_cmd) begin
               state_d   = ST_READ;
               chk_start = 1'b1;
            end
         end
         ST_READ: begin
            if (rd_xfer && last_cmd) state_d = ST_WAIT_RD;
         end
         ST_WAIT_RD: begin
            if (rd_last) begin
               pass_cnt_d = pass_cnt_q + 16'd1;
               if ((STOP_ON_ERR != 0) && (err_flag || rd_mismatch)) begin
                  state_d = ST_DONE;
               end else begin
                  state_d    = ST_WRITE;
                  cmd_addr_d = START_ADDR;
                  cmd_cnt_d  = 16'd0;
`ifdef DDR3_TG_PRBS_EN
                  gen_lfsr_d = lfsr_seed(pass_cnt_d);
`endif
               end
            end
         end
         ST_DONE: begin
            state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cmd_addr_q <= '0;
         cmd_cnt_q  <= 16'd0;
         pass_cnt_q <= 16'd0;
`ifdef DDR3_TG_PRBS_EN
         gen_lfsr_q <= 32'h0;
`endif
      end else begin
         state_q    <= state_d;
         cmd_addr_q <= cmd_addr_d;
         cmd_cnt_q  <= cmd_cnt_d;
         pass_cnt_q <= pass_cnt_d;
`ifdef DDR3_TG_PRBS_EN
         gen_lfsr_q <= gen_lfsr_d;
`endif
      end
   end

   assign chk_active = (state_q == ST_READ) || (state_q == ST_WAIT_RD);

   ddr3_tg_checker #(
      .ADDR_WIDTH     (ADDR_WIDTH),
      .APP_DATA_WIDTH (APP_DATA_WIDTH),
      .START_ADDR     (START_ADDR),
      .NUM_BURSTS     (NUM_BURSTS),
      .ADDR_STEP      (ADDR_STEP)
   ) u_checker (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (chk_start),
      .active      (chk_active),
      .pass        (pass_cnt_q),
      .rd_valid    (app_rd_data_valid),
      .rd_data     (app_rd_data),
      .rd_last     (rd_last),
      .rd_mismatch (rd_mismatch),
      .cmp_err     (err_flag),
      .err_addr    (err_addr)
   );

   assign app_en           = (state_q == ST_WRITE) || (state_q == ST_READ);
   assign app_cmd          = (state_q == ST_READ) ? CMD_READ : CMD_WRITE;
   assign app_addr         = cmd_addr_q;
   assign app_wdf_wren     = (state_q == ST_WRITE);
   assign app_wdf_end      = app_wdf_wren;
   assign app_wdf_mask     = '0;
   assign app_wdf_data     = app_wdf_wren ? {REP{pattern(cmd_addr_q[27:0], pass_cnt_q, gen_lfsr)}}
                                          : '0;
   assign tg_compare_error = err_flag;
   assign pass_cnt         = pass_cnt_q;

endmodule

// File: tb/tb_ddr3_traffic_gen.sv
// Bench for ddr3_traffic_gen: random-ready UI memory model with in-order read returns, a pass-level
// reference model of the write/read traffic and directed calibration, stall, error and reset cases.
module tb_ddr3_traffic_gen;

   localparam int          AW    = 28;
   localparam int          DW    = 64;
   localparam int          MW    = 8;
   localparam int          NB    = 4;
   localparam logic [27:0] START = 28'h0;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          init_calib_complete = 1'b0;
   logic          app_rdy = 1'b0;
   logic          app_wdf_rdy = 1'b0;
   logic [DW-1:0] app_rd_data = '0;
   logic          app_rd_data_valid = 1'b0;
   logic          app_rd_data_end = 1'b0;
   logic [AW-1:0] app_addr;
   logic [2:0]    app_cmd;
   logic          app_en;
   logic [DW-1:0] app_wdf_data;
   logic          app_wdf_end;
   logic [MW-1:0] app_wdf_mask;
   logic          app_wdf_wren;
   logic          tg_compare_error;
   logic [15:0]   pass_cnt;
   logic [AW-1:0] err_addr;

   always #5 clk = ~clk;

   ddr3_traffic_gen #(
      .ADDR_WIDTH(AW), .APP_DATA_WIDTH(DW), .APP_MASK_WIDTH(MW), .START_ADDR(START),
      .NUM_BURSTS(NB), .ADDR_STEP(8), .STOP_ON_ERR(1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .init_calib_complete(init_calib_complete),
      .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy), .app_rd_data(app_rd_data),
      .app_rd_data_valid(app_rd_data_valid), .app_rd_data_end(app_rd_data_end),
      .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_wdf_data(app_wdf_data),
      .app_wdf_end(app_wdf_end), .app_wdf_mask(app_wdf_mask), .app_wdf_wren(app_wdf_wren),
      .tg_compare_error(tg_compare_error), .pass_cnt(pass_cnt), .err_addr(err_addr)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference data word for write number idx of pass p at address a
   function automatic logic [63:0] ref_word(input int p, input int idx, input logic [27:0] a);
      logic [31:0] w;
`ifdef DDR3_TG_PRBS_EN
      w = {16'(p), 16'hACE1};
      for (int k = 0; k < idx; k++) w = w[0] ? ((w >> 1) ^ 32'h8020_0003) : (w >> 1);
`else
      logic [3:0] p4;
      p4 = 4'(p);
      w = {p4, a};
      if (idx < 0) w = 32'h0;
`endif
      return {w, w};
   endfunction

   // Stimulus knobs, written only by the main sequence
   logic ideal = 1'b1;
   int   lat_lo = 1, lat_hi = 1;
   int   stall_req = 0;
   logic corrupt_on = 1'b0;
   logic keep_stale = 1'b0;

   // Model state, written only by the monitor
   typedef struct { logic [27:0] addr; int due; } rd_t;
   rd_t           rd_q[$];
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] mem [logic [27:0]];
   int   cyc = 0, last_due = 0;
   int   m_pass = 0, m_wr = 0, m_rdc = 0, m_beats = 0;
   logic m_err = 1'b0, m_stopped = 1'b0;
   logic [27:0] m_err_addr = '0;
   int   stall_used = 0, stale_beats = 0;

   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            m_pass = 0; m_wr = 0; m_rdc = 0; m_beats = 0;
            m_err = 1'b0; m_stopped = 1'b0; m_err_addr = '0;
            exp_q.delete();
            if (!keep_stale) begin
               rd_q.delete();
               last_due = 0;
            end
         end else begin
            check("pass_cnt", 64'(pass_cnt), 64'(16'(m_pass)));
            check("cmp_err", 64'(tg_compare_error), 64'(m_err));
            check("err_addr", 64'(err_addr), 64'(m_err_addr));
            check("wren", 64'(app_wdf_wren), 64'(app_en && app_cmd == 3'b000));
            check("wdf_end", 64'(app_wdf_end), 64'(app_en && app_cmd == 3'b000));
            check("mask", 64'(app_wdf_mask), 64'd0);
         end

         app_rdy     = ideal ? 1'b1 : ($urandom_range(0, 3) != 0);
         app_wdf_rdy = ideal ? 1'b1 : ($urandom_range(0, 3) != 0);
         if (rst_n && app_en && m_wr == 1 && stall_used < stall_req) begin
            app_wdf_rdy = 1'b0;
            stall_used++;
         end

         if (rst_n && app_en) begin
            if (m_stopped || (m_wr == NB && m_rdc == NB)) begin
               check("unexp_en", 64'(app_en), 64'd0);
            end else if (m_wr < NB) begin
               if (exp_q.size() == 0)
                  for (int i = 0; i < NB; i++)
                     exp_q.push_back(ref_word(m_pass, i, START + 28'(8 * i)));
               check("wr_cmd", 64'(app_cmd), 64'd0);
               check("wr_addr", 64'(app_addr), 64'(START + 28'(8 * m_wr)));
               check("wr_data", app_wdf_data, exp_q[0]);
               if (app_rdy && app_wdf_rdy) begin
                  mem[START + 28'(8 * m_wr)] = exp_q[0];
                  void'(exp_q.pop_front());
                  m_wr++;
               end
            end else begin
               check("rd_cmd", 64'(app_cmd), 64'd1);
               check("rd_addr", 64'(app_addr), 64'(START + 28'(8 * m_rdc)));
               if (app_rdy) begin
                  rd_t e;
                  int  lat;
                  lat = int'($urandom_range(lat_hi, lat_lo));
                  e.addr = START + 28'(8 * m_rdc);
                  e.due  = (cyc + lat > last_due) ? cyc + lat : last_due;
                  last_due = e.due;
                  rd_q.push_back(e);
                  m_rdc++;
               end
            end
         end

         app_rd_data_valid = 1'b0;
         app_rd_data = {$urandom, $urandom};
         app_rd_data_end = 1'b0;
         if (rd_q.size() > 0 && rd_q[0].due <= cyc && (ideal || $urandom_range(0, 3) != 0)) begin
            rd_t e;
            logic [DW-1:0] d;
            e = rd_q.pop_front();
            d = mem.exists(e.addr) ? mem[e.addr] : '0;
            if (rst_n && m_wr == NB) begin
               if (corrupt_on && m_pass == 0 && e.addr == 28'd16) begin
                  d[3] = ~d[3];
                  if (!m_err) m_err_addr = e.addr;
                  m_err = 1'b1;
               end
               m_beats++;
               if (m_beats == NB) begin
                  m_pass++; m_wr = 0; m_rdc = 0; m_beats = 0;
                  if (m_err) m_stopped = 1'b1;
               end
            end else if (rst_n) begin
               stale_beats++;
            end
            app_rd_data_valid = 1'b1;
            app_rd_data_end   = 1'b1;
            app_rd_data       = d;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset(input int cycles);
      rst_n = 1'b0;
      repeat (cycles) tick();
      rst_n = 1'b1;
   endtask

   task automatic check_outputs_zero(input string t);
      check({t, "_en"}, 64'(app_en), 64'd0);
      check({t, "_cmd"}, 64'(app_cmd), 64'd0);
      check({t, "_addr"}, 64'(app_addr), 64'd0);
      check({t, "_wren"}, 64'(app_wdf_wren), 64'd0);
      check({t, "_end"}, 64'(app_wdf_end), 64'd0);
      check({t, "_data"}, app_wdf_data, 64'd0);
      check({t, "_err"}, 64'(tg_compare_error), 64'd0);
      check({t, "_pass"}, 64'(pass_cnt), 64'd0);
      check({t, "_eaddr"}, 64'(err_addr), 64'd0);
   endtask

   task automatic wait_pass(input int target, input int budget);
      int n;
      n = 0;
      while (m_pass < target && n < budget) begin
         tick();
         n++;
      end
      check("pass_reached", 64'(m_pass >= target), 64'd1);
   endtask

   initial begin
      int n;
      // reset state
      rst_n = 1'b0;
      repeat (3) tick();
      check_outputs_zero("rst");
      rst_n = 1'b1;

      // calibration held low: no traffic
      for (int i = 0; i < 100; i++) begin
         tick();
         check("calib_idle_en", 64'(app_en), 64'd0);
      end

      // first pass: ideal memory, 5-cycle data stall on the second write
      stall_req = 5;
      init_calib_complete = 1'b1;
      tick();
      check("first_wr_en", 64'(app_en), 64'd1);
      check("first_wr_addr", 64'(app_addr), 64'd0);
      check("first_wr_data", app_wdf_data, ref_word(0, 0, 28'd0));
      wait_pass(1, 400);
      check("stall_cycles", 64'(stall_used), 64'd5);

      // random ready/latency across the 4-bit pass-number wrap
      ideal = 1'b0;
      lat_lo = 1;
      lat_hi = 6;
      wait_pass(18, 6000);
      check("no_err_random", 64'(tg_compare_error), 64'd0);

      // corrupted read at address 16 in pass 0: drain then DONE
      corrupt_on = 1'b1;
      init_calib_complete = 1'b0;
      do_reset(2);
      init_calib_complete = 1'b1;
      n = 0;
      while (!(m_stopped && rd_q.size() == 0) && n < 3000) begin
         tick();
         n++;
      end
      check("stop_reached", 64'(m_stopped && rd_q.size() == 0), 64'd1);
      repeat (3) tick();
      check("err_flag", 64'(tg_compare_error), 64'd1);
      check("err_addr16", 64'(err_addr), 64'd16);
      check("err_pass", 64'(pass_cnt), 64'd1);
      for (int i = 0; i < 20; i++) begin
         tick();
         check("done_en", 64'(app_en), 64'd0);
      end

      // reset in WAIT_RD with two reads outstanding; their beats arrive in IDLE
      corrupt_on = 1'b0;
      init_calib_complete = 1'b0;
      do_reset(2);
      ideal = 1'b1;
      lat_lo = 10;
      lat_hi = 10;
      init_calib_complete = 1'b1;
      n = 0;
      while (!(m_rdc == NB && m_beats == 2) && n < 500) begin
         tick();
         n++;
      end
      check("wait_rd_sync", 64'(m_rdc == NB && m_beats == 2), 64'd1);
      keep_stale = 1'b1;
      init_calib_complete = 1'b0;
      rst_n = 1'b0;
      tick();
      check_outputs_zero("midrst");
      rst_n = 1'b1;
      for (int i = 0; i < 15; i++) begin
         tick();
         check("stale_en", 64'(app_en), 64'd0);
         check("stale_err", 64'(tg_compare_error), 64'd0);
         check("stale_pass", 64'(pass_cnt), 64'd0);
      end
      check("stale_seen", 64'(stale_beats > 0), 64'd1);
      keep_stale = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ddr3_traffic_gen.md
Name: ddr3_traffic_gen

Overview:
- Write/read-back traffic generator and checker on the MIG user interface (UI) of the DDR3 controller core. Sits directly upstream of the controller and drives its app_* command, write-data and read-data ports.
- Once calibration completes, it writes a deterministic pattern over an address window, then reads the window back and compares every beat. It repeats in numbered passes.
- A sticky compare error is exported as tg_compare_error to the board/test top level.

Parameters:
- ADDR_WIDTH, 28, UI address width (app_addr).
- APP_DATA_WIDTH, 64, UI data width; must be a multiple of 32.
- APP_MASK_WIDTH, 8, APP_DATA_WIDTH/8.
- START_ADDR, 28'h0000000, first address of the test window; must be 8-aligned.
- NUM_BURSTS, 256, commands per phase; must be ≥1 and ≤ 2^16.
- ADDR_STEP, 8, address increment per command (BL8, one UI beat per command).
- STOP_ON_ERR, 1, when 1 the block halts in DONE on the first mismatch; when 0 it keeps running.

Ports:
- clk  in  1  UI clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- init_calib_complete  in  1  from controller; traffic starts only when this is high.
- app_rdy  in  1  controller accepts command.
- app_wdf_rdy  in  1  controller accepts write data.
- app_rd_data  in  APP_DATA_WIDTH  read return data.
- app_rd_data_valid  in  1  read beat valid.
- app_rd_data_end  in  1  last beat of burst; ignored (one beat per burst).
- app_addr  out  ADDR_WIDTH  command address.
- app_cmd  out  3  3'b000 = write, 3'b001 = read.
- app_en  out  1  command valid.
- app_wdf_data  out  APP_DATA_WIDTH  write data.
- app_wdf_end  out  1  equals app_wdf_wren.
- app_wdf_mask  out  APP_MASK_WIDTH  always 0.
- app_wdf_wren  out  1  write data valid.
- tg_compare_error  out  1  sticky mismatch flag.
- pass_cnt  out  16  completed write+read passes.
- err_addr  out  ADDR_WIDTH  address of the first mismatching beat.

Behaviour:
- Reset (rst_n = 0 at a clk edge) clears every output to 0 and puts the FSM in IDLE. This applies mid-operation too: an outstanding command or pending read return is abandoned. Read-valid beats arriving after reset is released while the FSM is in IDLE are ignored.
- FSM states: IDLE, WRITE, READ, WAIT_RD, DONE.
- IDLE:
  - Wait for init_calib_complete = 1.
  - Then load cmd_addr = START_ADDR, cmd_cnt = 0, and go to WRITE.
- WRITE:
  - Assert app_en = 1 with app_cmd = 000, and app_wdf_wren = app_wdf_end = 1, all in the same cycle. Command and data are presented together.
  - Hold all of them stable until a cycle where app_rdy & app_wdf_rdy = 1. That cycle is a transfer.
  - On a transfer: cmd_addr += ADDR_STEP and cmd_cnt += 1.
  - After transfer number NUM_BURSTS: reload cmd_addr = START_ADDR, cmd_cnt = 0, and go to READ. There is no idle cycle between phases.
- Write pattern for address A in pass P:
  - W32 = {P[3:0], A[27:0]}.
  - app_wdf_data = W32 replicated APP_DATA_WIDTH/32 times.
- READ:
  - Assert app_en = 1 with app_cmd = 001. Advance on app_rdy = 1.
  - After NUM_BURSTS accepted commands, go to WAIT_RD.
- Checker (runs independently):
  - Keeps its own expected address exp_addr (reset to START_ADDR at entry to READ) and a counter rd_cnt.
  - On each app_rd_data_valid: compare app_rd_data with the pattern for exp_addr; exp_addr += ADDR_STEP; rd_cnt += 1.
  - Read data returns in command order.
  - The checker is active in READ and WAIT_RD. In READ, data may return before all commands are issued.
- Mismatch handling:
  - tg_compare_error is set on the cycle after the mismatching beat.
  - err_addr latches exp_addr only on the first mismatch since reset.
  - Both hold until reset.
- WAIT_RD:
  - When rd_cnt == NUM_BURSTS (counting the beat in the current cycle), pass_cnt += 1.
  - Then go to DONE if STOP_ON_ERR and (error flag is set or the current beat mismatches); otherwise go to WRITE with the address reloaded.
- STOP_ON_ERR = 1 with a mismatch during READ: issuing continues until all commands are sent and all reads have returned, then the FSM enters DONE. This keeps the controller queue drained.
- DONE: all strobes 0; the FSM stays here until reset.
- init_calib_complete dropping after start is ignored.
- pass_cnt wraps from 0xFFFF to 0. The pattern uses P[3:0], which wraps every 16 passes.
- Read latency is unbounded; there is no timeout.

Optional Feature:
- Macro: DDR3_TG_PRBS_EN.
- Defined:
  - W32 comes from a 32-bit Galois LFSR (x^32 + x^22 + x^2 + x + 1).
  - The generator's LFSR is seeded with {P[15:0], 16'hACE1} at entry to WRITE and advances once per write transfer.
  - The checker's LFSR gets the same seed at entry to READ and advances once per read-valid beat.
  - Data = W32 replicated, as in the address pattern.
- Undefined: the address pattern described above; no LFSR logic is synthesised.

Decomposition:
- Shared package ddr3_tg_pkg holds:
  - the UI command constants (CMD_WRITE = 3'b000, CMD_READ = 3'b001);
  - the FSM state encoding;
  - the LFSR polynomial and seed constant;
  - the pattern function pattern(addr, pass, lfsr).
- One sub-module, ddr3_tg_checker, holds exp_addr, rd_cnt, the compare, err_addr and the sticky flag. The top level holds the FSM and the generator.

Test Plan:
1. NUM_BURSTS = 4, ideal memory model with app_rdy = app_wdf_rdy = 1 → writes to addresses 0, 8, 16, 24 with data 0x00000000_00000000 … 0x00000018_00000018; then 4 reads; pass_cnt = 1 after the 4th beat; tg_compare_error = 0.
2. init_calib_complete held low for 100 cycles → app_en = 0 throughout; the first write occurs 1 cycle after it rises.
3. app_wdf_rdy = 0 for 5 cycles on the 2nd write → app_en, app_addr = 8 and data held stable; no address skip.
4. Model corrupts bit 3 of the read at address 16 in pass 0, STOP_ON_ERR = 1 → tg_compare_error = 1; err_addr = 16; remaining reads drain; FSM reaches DONE; pass_cnt = 1; no further app_en.
5. rst_n pulsed low in WAIT_RD with 2 reads outstanding → all outputs 0 next cycle; stale read-valid beats ignored; flag stays 0.
6. DDR3_TG_PRBS_EN defined, 3 passes → write data equals the reference LFSR sequence; no error; pass_cnt = 3.
